ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//  Multi-channel HC-SR04-style ranger: time-multiplexes NUM_CH sensors, issues a TRIG_US
//  trigger pulse per measurement slot, times the returned echo in microseconds and cm.
//  Successor to the fixed single-channel trigger generator; adds echo capture, timeout,
//  channel masking and a result strobe. Feeds display/control logic in the sensor subsystem.
// PARAMETERS
//  NUM_CH     2       sensor channels (1..8)
//  TICK_DIV   100     clk cycles per 1 us tick (100 MHz clk)
//  TRIG_US    10      trigger high time, us
//  PERIOD_US  100000  slot length per channel, us (trigger-to-next-trigger)
//  TIMEOUT_US 30000   max echo wait and max echo width, us; must be < PERIOD_US - TRIG_US
//  CM_DIV     58      us of echo per cm
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous, active-high reset
//  enable     in   1        1 = run slots; 0 = stop after current slot
//  ch_mask    in   NUM_CH   bit i = channel i participates
//  echo       in   NUM_CH   raw echo inputs (asynchronous)
//  trigger    out  NUM_CH   trigger outputs; at most one high at a time
//  res_valid  out  1        1-cycle strobe: result fields valid
//  res_ch     out  3        channel of this result
//  res_us     out  16       echo width, us (saturates at TIMEOUT_US)
//  res_cm     out  16       res_us / CM_DIV, truncated
//  res_timeout out 1        1 = no echo rise, or echo not fallen, within TIMEOUT_US
//  busy       out  1        slot in progress
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; prescaler, slot and echo counters 0; channel ptr 0.
//  Tick: prescaler 0..TICK_DIV-1, tick=1 on cycle where count==TICK_DIV-1. All us timing on ticks.
//  Echo: 2-flop synchroniser per channel, then edge detect; only selected channel observed.
//  FSM: IDLE -> TRIG -> WAIT_RISE -> MEASURE -> HOLD -> (SELECT) ...
//   IDLE: when enable && |ch_mask: pick next set mask bit at/after ptr (round-robin, wrap), go TRIG
//     at the next tick; slot_us cleared. Otherwise stay, busy=0.
//   TRIG: trigger[ch]=1 for exactly TRIG_US ticks (TRIG_US*TICK_DIV cycles), then WAIT_RISE.
//   WAIT_RISE: needs synchronised rising edge; echo already high on entry is ignored until it
//     falls and rises again. wait_us reaching TIMEOUT_US -> result (timeout=1, us=0, cm=0), HOLD.
//   MEASURE: echo_us increments per tick; cm sub-counter wraps at CM_DIV-1 and bumps cm.
//     Falling edge -> result (timeout=0) -> HOLD. echo_us reaching TIMEOUT_US -> result with
//     us=TIMEOUT_US, cm=TIMEOUT_US/CM_DIV, timeout=1 -> HOLD.
//   HOLD: wait until slot_us == PERIOD_US-1 on a tick; ptr=ch+1 (wrap); if enable -> select next
//     channel and TRIG immediately (slot period exact), else IDLE.
//  Result: res_* registered, res_valid 1 cycle on entry to HOLD; fields hold until next result.
//  busy=1 in TRIG/WAIT_RISE/MEASURE/HOLD.
//  ch_mask/enable sampled only at slot selection; mid-slot changes affect the next slot only.
//  Mask bit of active channel cleared mid-slot: slot still completes and reports.
//  Simultaneous falling edge and timeout on same tick: edge wins (timeout=0, us=TIMEOUT_US).
//  rst mid-slot: trigger drops next cycle, no result emitted, restart from channel 0.
// STRUCTURE
//  Package ultrasonic_pkg: state enum (IDLE,TRIG,WAIT_RISE,MEASURE,HOLD), US_W=17, CH_W=3.
//  Sub-module us_tick_gen (prescaler, param TICK_DIV, ports clk,rst,tick); rest in one FSM.
// TESTING (bench params TICK_DIV=4, TRIG_US=10, PERIOD_US=400, TIMEOUT_US=300, NUM_CH=2)
//  1 mask=01, enable; echo0 high 116 us after trigger fall -> trigger0 high 40 clks, res_us=116, res_cm=2, ch=0.
//  2 mask=11, no echoes -> alternating trigger0/trigger1 every 1600 clks; each res_timeout=1, us=0.
//  3 echo held high 400 us -> res_us=300, res_cm=5, res_timeout=1; next trigger still on slot boundary.
//  4 echo high before trigger, falls, rises 20 us later, high 58 us -> res_us=58, res_cm=1.
//  5 enable dropped mid-MEASURE -> that result still issued, then IDLE, trigger=0, busy=0.
//  6 rst mid-TRIG -> trigger low next cycle, no res_valid; after release restarts with ch 0.

Source files
------------

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic ranger.
package ultrasonic_pkg;

    localparam int US_W = 17;
    localparam int CH_W = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    // Round-robin pick: first set mask bit at or after 'start', wrapping at num_ch.
    // With an empty mask the start channel is returned; callers gate on |mask.
    function automatic logic [CH_W-1:0] pick_ch(input logic [7:0]      mask,
                                                 input logic [CH_W-1:0] start,
                                                 input int              num_ch);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(start) + i) % num_ch;
            if (!found && (i < num_ch) && mask[CH_W'(idx)]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler: one-cycle tick every TICK_DIV clocks.
module us_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Free-running prescaler 0..TICK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Multi-channel HC-SR04-style ranger: round-robin trigger slots, echo timing in us and cm.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int TICK_DIV   = 100,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 100000,
    parameter int TIMEOUT_US = 30000,
    parameter int CM_DIV     = 58
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [15:0]       res_us,
    output logic [15:0]       res_cm,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [US_W-1:0] TRIG_END   = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0] PERIOD_END = US_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0] TMO_END    = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0] CM_END     = US_W'(CM_DIV - 1);
    localparam logic [15:0]     TMO_US16   = 16'(TIMEOUT_US);
    localparam logic [15:0]     TMO_CM16   = 16'(TIMEOUT_US / CM_DIV);
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);

    state_t state, state_nxt;

    logic              tick;
    logic [NUM_CH-1:0] echo_p0, echo_p1;
    logic              echo_sel, echo_prev;
    logic              rise, fall;
    logic [7:0]        mask8;

    logic [CH_W-1:0]   ch, ptr, next_ptr, sel_start, sel_ch;
    logic              sel_ok, hold_done, start_slot;

    logic [US_W-1:0]   slot_us, wait_us, echo_us, cm_sub, cm_cnt;
    logic [US_W-1:0]   us_inc, cm_sub_inc, cm_inc;
    logic              cm_wrap;

    us_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchroniser on every raw echo input
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_p0 <= '0;
            echo_p1 <= '0;
        end else begin
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
        end
    end

    // Route the active channel's echo and widen the mask for the selector
    always_comb begin
        echo_sel = 1'b0;
        mask8    = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) echo_sel = echo_p1[i];
            mask8[i] = ch_mask[i];
        end
    end

    assign rise       = echo_sel & ~echo_prev;
    assign fall       = ~echo_sel & echo_prev;
    assign next_ptr   = (ch == LAST_CH) ? '0 : ch + CH_W'(1);
    assign sel_start  = (state == HOLD) ? next_ptr : ptr;
    assign sel_ch     = pick_ch(mask8, sel_start, NUM_CH);
    assign sel_ok     = enable && (|ch_mask);
    // >= covers a long wait+echo overrunning the slot: the next slot then starts on the next tick
    assign hold_done  = tick && (slot_us >= PERIOD_END);
    assign start_slot = (state_nxt == TRIG) && (state != TRIG);

    // Echo width and cm counters including the tick of the current cycle, so a
    // falling edge on a tick reports the full count
    assign us_inc     = echo_us + US_W'(tick);
    assign cm_wrap    = tick && (cm_sub == CM_END);
    assign cm_sub_inc = cm_wrap ? '0 : cm_sub + US_W'(tick);
    assign cm_inc     = cm_cnt + US_W'(cm_wrap);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tick && sel_ok) state_nxt = TRIG;
            end
            TRIG: begin
                if (tick && (slot_us == TRIG_END)) state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise)                                state_nxt = MEASURE;
                else if (tick && (wait_us == TMO_END))   state_nxt = HOLD;
            end
            MEASURE: begin
                if (fall)                                state_nxt = HOLD;
                else if (tick && (echo_us == TMO_END))   state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_done) state_nxt = sel_ok ? TRIG : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and channel
    always_comb begin
        trigger = '0;
        busy    = (state != IDLE);
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state == TRIG) && (ch == CH_W'(i))) trigger[i] = 1'b1;
        end
    end

    // Slot bookkeeping, echo counters and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_prev   <= 1'b0;
            ch          <= '0;
            ptr         <= '0;
            slot_us     <= '0;
            wait_us     <= '0;
            echo_us     <= '0;
            cm_sub      <= '0;
            cm_cnt      <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_us      <= '0;
            res_cm      <= '0;
            res_timeout <= 1'b0;
        end else begin
            echo_prev <= echo_sel;
            res_valid <= 1'b0;

            if (tick) slot_us <= slot_us + US_W'(1);

            if ((state == WAIT_RISE) && tick) wait_us <= wait_us + US_W'(1);

            if (state == MEASURE) begin
                echo_us <= us_inc;
                cm_sub  <= cm_sub_inc;
                cm_cnt  <= cm_inc;
            end

            if ((state == HOLD) && hold_done) ptr <= next_ptr;

            if (start_slot) begin
                ch      <= sel_ch;
                slot_us <= '0;
                wait_us <= '0;
                echo_us <= '0;
                cm_sub  <= '0;
                cm_cnt  <= '0;
            end

            if ((state_nxt == HOLD) && (state == WAIT_RISE)) begin
                res_valid   <= 1'b1;
                res_ch      <= 3'(ch);
                res_us      <= '0;
                res_cm      <= '0;
                res_timeout <= 1'b1;
            end

            if ((state_nxt == HOLD) && (state == MEASURE)) begin
                res_valid <= 1'b1;
                res_ch    <= 3'(ch);
                if (fall) begin
                    res_us      <= 16'(us_inc);
                    res_cm      <= 16'(cm_inc);
                    res_timeout <= 1'b0;
                end else begin
                    res_us      <= TMO_US16;
                    res_cm      <= TMO_CM16;
                    res_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: echo-pulse table plus slot/enable/reset sequences.
module tb_ultrasonic_ranger;

    localparam int NUM_CH     = 2;
    localparam int TICK_DIV   = 4;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 400;
    localparam int TIMEOUT_US = 300;
    localparam int CM_DIV     = 58;
    localparam int SLOT_CLKS  = PERIOD_US * TICK_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] trigger;
    logic              res_valid;
    logic [2:0]        res_ch;
    logic [15:0]       res_us;
    logic [15:0]       res_cm;
    logic              res_timeout;
    logic              busy;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int res_cnt = 0;
    int cap_ch, cap_us, cap_cm, cap_to;

    ultrasonic_ranger #(
        .NUM_CH    (NUM_CH),
        .TICK_DIV  (TICK_DIV),
        .TRIG_US   (TRIG_US),
        .PERIOD_US (PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US),
        .CM_DIV    (CM_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .echo       (echo),
        .trigger    (trigger),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_us     (res_us),
        .res_cm     (res_cm),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result strobe on the falling edge
    always @(negedge clk) begin
        if (res_valid) begin
            res_cnt <= res_cnt + 1;
            cap_ch  <= int'(res_ch);
            cap_us  <= int'(res_us);
            cap_cm  <= int'(res_cm);
            cap_to  <= int'(res_timeout);
        end
    end

    typedef struct {
        logic [1:0] mask;
        int         ch;
        bit         pre_high;
        int         rise_dly;
        int         width;
        int         exp_us;
        int         exp_cm;
        bit         exp_to;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(input int c, input int max, output int t);
        t = -1;
        for (int i = 0; (i < max) && (t < 0); i++) begin
            step();
            if (trigger[c]) t = cyc;
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL wait_trig%0d: no trigger within %0d cycles", c, max);
        end
    endtask

    task automatic trig_width(input int c, output int n);
        bit done;
        n    = 1;
        done = 1'b0;
        for (int i = 0; (i < 200) && !done; i++) begin
            step();
            if (trigger[c]) n++;
            else done = 1'b1;
        end
    endtask

    task automatic wait_res(input int prev, input int max);
        bit ok;
        ok = (res_cnt != prev);
        for (int i = 0; (i < max) && !ok; i++) begin
            step();
            if (res_cnt != prev) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_res: no result within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = !busy;
        for (int i = 0; (i < max) && !ok; i++) begin
            step();
            if (!busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", max);
        end
    endtask

    initial begin
        int t0, t1, t2, n, prev, es, seen;
        vec_t v;

        //            mask   ch pre dly width us  cm to
        vecs[0] = '{2'b01, 0, 1'b0, 5, 116, 116, 2, 1'b0};
        vecs[1] = '{2'b10, 1, 1'b0, 3,  58,  58, 1, 1'b0};
        vecs[2] = '{2'b01, 0, 1'b1, 20, 58,  58, 1, 1'b0};
        vecs[3] = '{2'b10, 1, 1'b0, 1,  57,  57, 0, 1'b0};
        vecs[4] = '{2'b01, 0, 1'b0, 2, 299, 299, 5, 1'b0};
        vecs[5] = '{2'b10, 1, 1'b0, 2, 350, 300, 5, 1'b1};
        vecs[6] = '{2'b01, 0, 1'b0, 0,   0,   0, 0, 1'b1};
        vecs[7] = '{2'b10, 1, 1'b0, 7,   1,   1, 0, 1'b0};

        rst     = 1'b1;
        enable  = 1'b0;
        ch_mask = '0;
        echo    = '0;
        steps(5);

        // Reset state
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_ch", int'(res_ch), 0);
        chk("rst_res_us", int'(res_us), 0);
        chk("rst_res_cm", int'(res_cm), 0);
        chk("rst_res_timeout", int'(res_timeout), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        steps(20);
        chk("idle_busy", int'(busy), 0);
        chk("idle_trigger", int'(trigger), 0);

        // Both channels, no echoes: alternating timeouts on exact slot spacing
        ch_mask = 2'b11;
        enable  = 1'b1;
        prev    = res_cnt;
        wait_trig(0, 20, t0);
        wait_res(prev, SLOT_CLKS);
        chk("alt_res0_ch", cap_ch, 0);
        chk("alt_res0_to", cap_to, 1);
        chk("alt_res0_us", cap_us, 0);
        wait_trig(1, SLOT_CLKS, t1);
        chk("alt_spacing01", t1 - t0, SLOT_CLKS);
        prev = res_cnt;
        wait_res(prev, SLOT_CLKS);
        chk("alt_res1_ch", cap_ch, 1);
        chk("alt_res1_to", cap_to, 1);
        chk("alt_res1_cm", cap_cm, 0);
        wait_trig(0, SLOT_CLKS, t2);
        chk("alt_spacing10", t2 - t1, SLOT_CLKS);
        enable = 1'b0;
        wait_idle(SLOT_CLKS + 100);

        // Echo-pulse table, one slot per entry
        for (int k = 0; k < 8; k++) begin
            v       = vecs[k];
            ch_mask = v.mask;
            prev    = res_cnt;
            if (v.pre_high) echo[v.ch] = 1'b1;
            enable = 1'b1;
            wait_trig(v.ch, 20, t0);
            chk($sformatf("v%0d_trig_onehot", k), int'(trigger), 1 << v.ch);
            trig_width(v.ch, n);
            chk($sformatf("v%0d_trig_width", k), n, TRIG_US * TICK_DIV);
            if (v.pre_high) begin
                steps(5 * TICK_DIV);
                echo[v.ch] = 1'b0;
            end
            steps(v.rise_dly * TICK_DIV);
            if (v.width > 0) begin
                echo[v.ch] = 1'b1;
                steps(v.width * TICK_DIV);
                echo[v.ch] = 1'b0;
            end
            enable = 1'b0;
            wait_res(prev, SLOT_CLKS);
            chk($sformatf("v%0d_res_ch", k), cap_ch, v.ch);
            chk($sformatf("v%0d_res_us", k), cap_us, v.exp_us);
            chk($sformatf("v%0d_res_cm", k), cap_cm, v.exp_cm);
            chk($sformatf("v%0d_res_to", k), cap_to, int'(v.exp_to));
            chk($sformatf("v%0d_res_pulses", k), res_cnt - prev, 1);
            wait_idle(SLOT_CLKS + 100);
        end

        // Echo stuck high: saturated timeout result, next trigger still on the slot boundary
        ch_mask = 2'b01;
        enable  = 1'b1;
        prev    = res_cnt;
        wait_trig(0, 20, t0);
        trig_width(0, n);
        steps(10 * TICK_DIV);
        echo[0] = 1'b1;
        es      = cyc;
        wait_res(prev, SLOT_CLKS);
        chk("stuck_res_us", cap_us, TIMEOUT_US);
        chk("stuck_res_cm", cap_cm, TIMEOUT_US / CM_DIV);
        chk("stuck_res_to", cap_to, 1);
        wait_trig(0, SLOT_CLKS, t1);
        chk("stuck_next_trig", t1 - t0, SLOT_CLKS);
        while (cyc < es + 400 * TICK_DIV) step();
        echo[0] = 1'b0;
        enable  = 1'b0;
        wait_idle(2 * SLOT_CLKS);

        // Enable dropped mid-measure: result still issued, then idle with no further trigger
        ch_mask = 2'b01;
        enable  = 1'b1;
        prev    = res_cnt;
        wait_trig(0, 20, t0);
        trig_width(0, n);
        steps(2 * TICK_DIV);
        echo[0] = 1'b1;
        steps(50 * TICK_DIV);
        chk("endrop_busy", int'(busy), 1);
        enable = 1'b0;
        steps(50 * TICK_DIV);
        echo[0] = 1'b0;
        wait_res(prev, SLOT_CLKS);
        chk("endrop_res_us", cap_us, 100);
        chk("endrop_res_cm", cap_cm, 1);
        chk("endrop_res_to", cap_to, 0);
        wait_idle(SLOT_CLKS + 100);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (trigger != 0 || busy) seen++;
        end
        chk("endrop_quiet", seen, 0);

        // Reset in the middle of a channel-1 trigger pulse
        ch_mask = 2'b11;
        enable  = 1'b1;
        wait_trig(1, 2 * SLOT_CLKS + 100, t0);
        steps(20);
        prev = res_cnt;
        rst  = 1'b1;
        step();
        chk("midrst_trigger", int'(trigger), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        t1  = -1;
        for (int i = 0; (i < 20) && (t1 < 0); i++) begin
            step();
            if (trigger != 0) t1 = cyc;
        end
        chk("midrst_restart_seen", int'(t1 >= 0), 1);
        chk("midrst_restart_ch0", int'(trigger), 1);
        steps(100);
        chk("midrst_no_result", res_cnt - prev, 0);
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
